// File: rtl/soc_pkg.sv
// Shared SoC constants: bus widths, arbiter state encoding, UART1 address.
package soc_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 8;

  localparam int unsigned TIMEOUT_DEF = 255;

  localparam logic [ADR_W-1:0] UART1_BASE = 32'h1000_0100;

  // One-hot arbiter states
  localparam int unsigned ST_W = 4;
  typedef logic [ST_W-1:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 4'b0001;
  localparam arb_state_t ST_GNT0  = 4'b0010;
  localparam arb_state_t ST_GNT1  = 4'b0100;
  localparam arb_state_t ST_ABORT = 4'b1000;

endpackage

// File: rtl/wb_arb2_if.sv
// Two-master / one-slave Wishbone bundle around the UART arbiter.
interface wb_arb2_if;
  import soc_pkg::*;

  logic [ADR_W-1:0] m0_adr_i;
  logic [DAT_W-1:0] m0_dat_i;
  logic             m0_we_i;
  logic [SEL_W-1:0] m0_sel_i;
  logic             m0_stb_i;
  logic             m0_cyc_i;
  logic [DAT_W-1:0] m0_dat_o;
  logic             m0_ack_o;
  logic             m0_err_o;

  logic [ADR_W-1:0] m1_adr_i;
  logic [DAT_W-1:0] m1_dat_i;
  logic             m1_we_i;
  logic [SEL_W-1:0] m1_sel_i;
  logic             m1_stb_i;
  logic             m1_cyc_i;
  logic [DAT_W-1:0] m1_dat_o;
  logic             m1_ack_o;
  logic             m1_err_o;

  logic [ADR_W-1:0] s_adr_o;
  logic [DAT_W-1:0] s_dat_o;
  logic             s_we_o;
  logic [SEL_W-1:0] s_sel_o;
  logic             s_stb_o;
  logic             s_cyc_o;
  logic [DAT_W-1:0] s_dat_i;
  logic             s_ack_i;

  // Environment side: drives master requests and slave responses
  modport master (
    output m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    output m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
    output s_dat_i, s_ack_i
  );

  // Arbiter side
  modport slave (
    input  m0_adr_i, m0_dat_i, m0_we_i, m0_sel_i, m0_stb_i, m0_cyc_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_adr_i, m1_dat_i, m1_we_i, m1_sel_i, m1_stb_i, m1_cyc_i,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o,
    input  s_dat_i, s_ack_i
  );

endinterface

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter for the shared UART port, with bus lock,
// round-robin or fixed priority, and an ack-wait timeout that aborts the cycle.
module wb_arb2
  import soc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic       clk_48_i,
  input  logic       rst_ni,
  wb_arb2_if.slave   bus,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  arb_state_t       state_q, state_d;
  logic             owner_q, owner_d;   // granted master, or last granted when idle
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q;

  logic gnt0_c, gnt1_c, gnt_c, hit_c;
  logic cyc_own_c, stb_own_c;

  assign gnt0_c    = (state_q == ST_GNT0);
  assign gnt1_c    = (state_q == ST_GNT1);
  assign gnt_c     = gnt0_c | gnt1_c;
  assign cyc_own_c = owner_q ? bus.m1_cyc_i : bus.m0_cyc_i;
  assign stb_own_c = owner_q ? bus.m1_stb_i : bus.m0_stb_i;

  // State, owner, wait counter and sticky timeout registers
  always_ff @(posedge clk_48_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      owner_q   <= 1'b1;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | hit_c;
    end
  end

  // Next-state, arbitration and timeout detection; a same-cycle ack beats the timeout
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    hit_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.m0_cyc_i && bus.m1_cyc_i) begin
          owner_d = RR_EN ? ~owner_q : 1'b0;
        end else if (bus.m0_cyc_i) begin
          owner_d = 1'b0;
        end else if (bus.m1_cyc_i) begin
          owner_d = 1'b1;
        end
        if (bus.m0_cyc_i || bus.m1_cyc_i) begin
          state_d = owner_d ? ST_GNT1 : ST_GNT0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (!cyc_own_c) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (bus.s_ack_i) begin
          cnt_d = '0;
        end else if (cnt_q == TMO) begin
          hit_c   = 1'b1;
          state_d = ST_ABORT;
          cnt_d   = '0;
        end else if (stb_own_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ABORT: begin
        cnt_d = '0;
        if (!cyc_own_c) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Slave port follows the granted master; zero outside a grant or on abort
  assign bus.s_cyc_o = gnt_c & ~hit_c;
  assign bus.s_stb_o = gnt_c & ~hit_c & stb_own_c & cyc_own_c;
  assign bus.s_adr_o = !gnt_c ? '0 : (owner_q ? bus.m1_adr_i : bus.m0_adr_i);
  assign bus.s_dat_o = !gnt_c ? '0 : (owner_q ? bus.m1_dat_i : bus.m0_dat_i);
  assign bus.s_we_o  = gnt_c & (owner_q ? bus.m1_we_i : bus.m0_we_i);
  assign bus.s_sel_o = !gnt_c ? '0 : (owner_q ? bus.m1_sel_i : bus.m0_sel_i);

  // Responses go only to the granted master
  assign bus.m0_ack_o = gnt0_c & bus.s_ack_i;
  assign bus.m1_ack_o = gnt1_c & bus.s_ack_i;
  assign bus.m0_dat_o = gnt0_c ? bus.s_dat_i : '0;
  assign bus.m1_dat_o = gnt1_c ? bus.s_dat_i : '0;
  assign bus.m0_err_o = hit_c & gnt0_c;
  assign bus.m1_err_o = hit_c & gnt1_c;

  assign grant_o   = {gnt1_c, gnt0_c};
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: latency, round-robin, bus lock, timeout, reset.
module tb_wb_arb2;
  import soc_pkg::*;

  logic       clk_48_i;
  logic       rst_ni;
  logic [1:0] grant;
  logic       timeout;

  int n_checks;
  int n_errors;

  wb_arb2_if bus ();

  wb_arb2 #(.TIMEOUT(4), .RR_EN(1'b1)) dut (
    .clk_48_i  (clk_48_i),
    .rst_ni    (rst_ni),
    .bus       (bus),
    .grant_o   (grant),
    .timeout_o (timeout)
  );

  initial clk_48_i = 1'b0;
  always #5 clk_48_i = ~clk_48_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_48_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus.m0_adr_i = '0; bus.m0_dat_i = '0; bus.m0_we_i = 1'b0;
    bus.m0_sel_i = '0; bus.m0_stb_i = 1'b0; bus.m0_cyc_i = 1'b0;
    bus.m1_adr_i = '0; bus.m1_dat_i = '0; bus.m1_we_i = 1'b0;
    bus.m1_sel_i = '0; bus.m1_stb_i = 1'b0; bus.m1_cyc_i = 1'b0;
    bus.s_dat_i  = '0; bus.s_ack_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_ni   = 1'b0;
    clear_inputs();
    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_scyc", 32'(bus.s_cyc_o), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_m0_ack", 32'(bus.m0_ack_o), 32'h0);
    step();
    step();
    rst_ni = 1'b1;
    step();

    // m0 alone reads 0x0FF, slave acks after 3 wait cycles
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    bus.m0_adr_i = 32'h0FF; bus.m0_sel_i = 4'hF;
    settle();
    chk("lat_still_idle", 32'(bus.s_cyc_o), 32'h0);
    step(); settle();
    chk("m0_scyc", 32'(bus.s_cyc_o), 32'h1);
    chk("m0_grant", 32'(grant), 32'h1);
    chk("m0_sadr", bus.s_adr_o, 32'h0FF);
    chk("m0_sstb", 32'(bus.s_stb_o), 32'h1);
    chk("m0_ssel", 32'(bus.s_sel_o), 32'hF);
    step(); step(); step();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h41;
    settle();
    chk("m0_ack", 32'(bus.m0_ack_o), 32'h1);
    chk("m0_dat", bus.m0_dat_o, 32'h41);
    chk("m1_ack_blocked", 32'(bus.m1_ack_o), 32'h0);
    chk("m1_dat_blocked", bus.m1_dat_o, 32'h0);
    chk("m0_no_err", 32'(bus.m0_err_o), 32'h0);
    step();
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    step(); settle();
    chk("rel_grant", 32'(grant), 32'h0);
    chk("rel_sadr", bus.s_adr_o, 32'h0);
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h55;
    settle();
    chk("idle_ack_ignored", 32'(bus.m0_ack_o), 32'h0);
    chk("idle_dat_ignored", bus.m0_dat_o, 32'h0);
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;

    // Simultaneous requests after reset: m0 first, m1 after one idle cycle
    do_reset();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h100;
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 32'h200; bus.m1_we_i = 1'b1;
    step(); settle();
    chk("tie_first_m0", 32'(grant), 32'h1);
    chk("tie_sadr_m0", bus.s_adr_o, 32'h100);
    bus.s_ack_i = 1'b1;
    settle();
    chk("tie_m0_ack", 32'(bus.m0_ack_o), 32'h1);
    chk("tie_m1_noack", 32'(bus.m1_ack_o), 32'h0);
    step();
    bus.s_ack_i = 1'b0;
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    step(); settle();
    chk("tie_idle_gap", 32'(grant), 32'h0);
    chk("tie_idle_scyc", 32'(bus.s_cyc_o), 32'h0);
    step(); settle();
    chk("tie_then_m1", 32'(grant), 32'h2);
    chk("tie_sadr_m1", bus.s_adr_o, 32'h200);
    chk("tie_swe_m1", 32'(bus.s_we_o), 32'h1);
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
    step(); settle();
    chk("m1_rel", 32'(grant), 32'h0);
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
    step(); settle();
    chk("tie_repeat_m0", 32'(grant), 32'h1);

    // m1 locks the bus over 3 write beats while m0 keeps requesting
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    step();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    step(); settle();
    chk("lock_m1_won", 32'(grant), 32'h2);
    for (int i = 0; i < 3; i++) begin
      bus.m1_stb_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_dat_i = 32'hA0 + 32'(i);
      settle();
      chk("lock_sdat", bus.s_dat_o, 32'hA0 + 32'(i));
      bus.s_ack_i = 1'b1;
      #1;
      chk("lock_m1_ack", 32'(bus.m1_ack_o), 32'h1);
      chk("lock_m0_noack", 32'(bus.m0_ack_o), 32'h0);
      step();
      bus.s_ack_i = 1'b0; bus.m1_stb_i = 1'b0;
      step(); settle();
      chk("lock_held", 32'(grant), 32'h2);
    end
    bus.m1_cyc_i = 1'b0; bus.m1_we_i = 1'b0;
    step(); settle();
    chk("lock_rel_idle", 32'(grant), 32'h0);
    step(); settle();
    chk("lock_m0_after", 32'(grant), 32'h1);
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    step(); step();

    // Slave never acks: err after 4 wait cycles, then ABORT until m0 drops cyc
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1; bus.m0_adr_i = 32'h300;
    step(); settle();
    chk("tmo_grant", 32'(grant), 32'h1);
    chk("tmo_err_e0", 32'(bus.m0_err_o), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      step(); settle();
      chk("tmo_wait_err", 32'(bus.m0_err_o), 32'h0);
      chk("tmo_wait_scyc", 32'(bus.s_cyc_o), 32'h1);
    end
    step(); settle();
    chk("tmo_err_pulse", 32'(bus.m0_err_o), 32'h1);
    chk("tmo_scyc_drop", 32'(bus.s_cyc_o), 32'h0);
    chk("tmo_sstb_drop", 32'(bus.s_stb_o), 32'h0);
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1;
    step(); settle();
    chk("tmo_err_once", 32'(bus.m0_err_o), 32'h0);
    chk("tmo_flag", 32'(timeout), 32'h1);
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_scyc", 32'(bus.s_cyc_o), 32'h0);
    bus.s_ack_i = 1'b1;
    settle();
    chk("abort_ack_ignored", 32'(bus.m0_ack_o), 32'h0);
    bus.s_ack_i = 1'b0;
    step(); settle();
    chk("abort_hold", 32'(grant), 32'h0);
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    step(); settle();
    chk("abort_to_idle", 32'(grant), 32'h0);
    step(); settle();
    chk("m1_after_abort", 32'(grant), 32'h2);
    chk("tmo_sticky", 32'(timeout), 32'h1);
    bus.m1_cyc_i = 1'b0; bus.m1_stb_i = 1'b0;
    step(); step();

    // Ack on the same cycle the counter hits TIMEOUT wins
    do_reset();
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    step();
    step(); step(); step(); step();
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h5A;
    settle();
    chk("race_ack", 32'(bus.m0_ack_o), 32'h1);
    chk("race_no_err", 32'(bus.m0_err_o), 32'h0);
    chk("race_scyc", 32'(bus.s_cyc_o), 32'h1);
    step();
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    settle();
    chk("race_no_tmo", 32'(timeout), 32'h0);
    chk("race_grant", 32'(grant), 32'h1);
    chk("race_scyc_kept", 32'(bus.s_cyc_o), 32'h1);
    bus.m0_cyc_i = 1'b0; bus.m0_stb_i = 1'b0;
    step(); step();

    // Reset pulse mid GNT1 beat clears outputs at once; next tie goes to m0
    bus.m1_cyc_i = 1'b1; bus.m1_stb_i = 1'b1; bus.m1_adr_i = 32'h400;
    step(); settle();
    chk("rb_grant_m1", 32'(grant), 32'h2);
    bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h77;
    settle();
    chk("rb_m1_ack", 32'(bus.m1_ack_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    chk("rb_grant", 32'(grant), 32'h0);
    chk("rb_scyc", 32'(bus.s_cyc_o), 32'h0);
    chk("rb_sadr", bus.s_adr_o, 32'h0);
    chk("rb_m1_ack", 32'(bus.m1_ack_o), 32'h0);
    chk("rb_m1_dat", bus.m1_dat_o, 32'h0);
    chk("rb_m1_err", 32'(bus.m1_err_o), 32'h0);
    bus.s_ack_i = 1'b0; bus.s_dat_i = '0;
    bus.m0_cyc_i = 1'b1; bus.m0_stb_i = 1'b1;
    step(); step();
    rst_ni = 1'b1;
    settle();
    chk("rb_idle", 32'(grant), 32'h0);
    step(); settle();
    chk("rb_tie_m0", 32'(grant), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles a granted strobe may wait for ack before abort (range 2..255).
REQ-002 SHALL have parameter RR_EN, default 1: 1 = round-robin, 0 = fixed priority with m0 highest.
REQ-003 SHALL have ports clk_48_i in 1, the single 48 MHz clock; rst_ni in 1, the asynchronous active-low reset.
REQ-004 SHALL have master-0 inputs m0_adr_i 32, m0_dat_i 32, m0_we_i 1, m0_sel_i 4, m0_stb_i 1, m0_cyc_i 1: CPU Wishbone request.
REQ-005 SHALL have master-0 outputs m0_dat_o 32, m0_ack_o 1, m0_err_o 1: CPU Wishbone response.
REQ-006 SHALL have master-1 ports identical to master 0 with prefix m1_: echo/service state-machine request and response.
REQ-007 SHALL have slave outputs s_adr_o 32, s_dat_o 32, s_we_o 1, s_sel_o 4, s_stb_o 1, s_cyc_o 1, and slave inputs s_dat_i 32, s_ack_i 1: the shared UART Wishbone port.
REQ-008 SHALL have outputs grant_o 2 (one-hot owner, 00 = none) and timeout_o 1 (sticky abort flag).

Function
REQ-009 SHALL run a one-hot FSM with states IDLE, GNT0, GNT1, ABORT.
REQ-010 IDLE: no request SHALL stay IDLE; single mX_cyc_i SHALL go GNTX next edge; both requesting with RR_EN=1 SHALL grant the master not granted last, with RR_EN=0 SHALL grant m0.
REQ-011 Arbitration latency SHALL be exactly one cycle, from mX_cyc_i high in IDLE to s_cyc_o high.
REQ-012 GNTX: s_adr/dat/we/sel_o SHALL equal master X's inputs combinationally; s_cyc_o=1; s_stb_o SHALL equal mX_stb_i AND mX_cyc_i.
REQ-013 GNTX: mX_ack_o SHALL equal s_ack_i and mX_dat_o SHALL equal s_dat_i combinationally; the non-granted master SHALL see ack=0, err=0, dat=0.
REQ-014 Grant SHALL be held while mX_cyc_i stays high, across multiple stb/ack beats (bus lock).
REQ-015 mX_cyc_i low in GNTX SHALL return to IDLE next edge, with one mandatory idle cycle before any new grant, and SHALL record X as last-granted.
REQ-016 Slave outputs SHALL be all zero when state is not GNT0 or GNT1.
REQ-017 An 8-bit wait counter SHALL clear on entry to GNTX and on each s_ack_i, increment while s_stb_o=1 and s_ack_i=0, and saturate at TIMEOUT.
REQ-018 Counter reaching TIMEOUT SHALL pulse mX_err_o for exactly one cycle, drop s_cyc_o and s_stb_o in that same cycle, set timeout_o, and go to ABORT.
REQ-019 ABORT SHALL keep slave outputs zero and SHALL return to IDLE only once the aborted master's cyc is low; the other master SHALL wait meanwhile.
REQ-020 When s_ack_i and timeout coincide on the same cycle, the ack SHALL win: the counter clears and no error is raised.
REQ-021 s_ack_i arriving in IDLE or ABORT SHALL be ignored and not forwarded.
REQ-022 timeout_o SHALL clear only on reset.

Reset
REQ-023 rst_ni low SHALL asynchronously force IDLE, grant_o=00, all slave outputs 0, all mX_ack_o/err_o/dat_o 0, counter 0, timeout_o 0, and last-granted=m1 (so m0 wins the first tie).
REQ-024 Reset asserted mid-transaction SHALL abandon the cycle with no ack or err pulse; after deassertion, arbitration SHALL restart from IDLE.

Structure
REQ-025 The state enum, TIMEOUT default, and the UART1 address constant SHALL live in shared package soc_pkg.
REQ-026 The block SHALL be a single module with no sub-modules; the timeout counter SHALL stay inline.

Verification
REQ-027 m0 alone reads 0x0FF, slave acks after 3 cycles with 0x41 -> s_cyc_o high 1 cycle after m0_cyc_i, m0_dat_o=0x41, grant_o=01.
REQ-028 m0 and m1 raise cyc on the same edge, RR_EN=1, after reset -> m0 granted first, m1 granted after m0 drops cyc plus 1 idle cycle; repeated tie -> m0 granted.
REQ-029 m1 holds cyc over 3 write beats while m0 requests -> m0 stays ungranted until m1 drops cyc; m0 sees no ack.
REQ-030 TIMEOUT=4, slave never acks -> m0_err_o pulses 1 cycle after 4 wait cycles, timeout_o=1, state ABORT until m0_cyc_i low.
REQ-031 s_ack_i arrives on the same cycle the counter hits TIMEOUT -> ack delivered, no err, timeout_o stays 0.
REQ-032 rst_ni pulsed low during a GNT1 beat -> all outputs 0 immediately, without waiting for a clock edge; next tie grants m0.
